// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   state_t          : FSM encoding (ST_LOAD=0, ST_RUN=1, ST_HALT=2), also driven on state_o
//   STATE_W          : width of the state encoding
//   ALIGN_MASK_*     : low-address-bit masks used to reject misaligned redirect targets
//   DEFAULT_*_VEC    : default reset and trap vectors
//   is_misaligned()  : alignment test on the low target bits under a given mask
package pc_seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Word-aligned targets for 4-byte instructions, halfword-aligned with compressed ones.
  localparam logic [1:0] ALIGN_MASK_WORD = 2'b11;
  localparam logic [1:0] ALIGN_MASK_HALF = 2'b01;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] mask);
    return (addr_lo & mask) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the pipeline front end and the
// program-counter sequencer.
//   Pipeline -> sequencer : loader_done_i, stall_i, redirect_valid_i, redirect_target_i,
//                           trap_valid_i, halt_i, resume_i
//                           (+ is_compressed_i when PC_COMPRESSED_EN is defined)
//   Sequencer -> pipeline : pc_o, pc_valid_o, misalign_o, misalign_addr_o, state_o
//   Modports: master = pipeline side, slave = sequencer side.
// Optional macro: PC_COMPRESSED_EN adds is_compressed_i.
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  import pc_seq_pkg::*;

  logic               loader_done_i;
  logic               stall_i;
  logic               redirect_valid_i;
  logic [XLEN-1:0]    redirect_target_i;
  logic               trap_valid_i;
  logic               halt_i;
  logic               resume_i;
`ifdef PC_COMPRESSED_EN
  logic               is_compressed_i;
`endif
  logic [XLEN-1:0]    pc_o;
  logic               pc_valid_o;
  logic               misalign_o;
  logic [XLEN-1:0]    misalign_addr_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    output loader_done_i, stall_i, redirect_valid_i, redirect_target_i,
           trap_valid_i, halt_i, resume_i,
`ifdef PC_COMPRESSED_EN
    output is_compressed_i,
`endif
    input  pc_o, pc_valid_o, misalign_o, misalign_addr_o, state_o
  );

  modport slave (
    input  loader_done_i, stall_i, redirect_valid_i, redirect_target_i,
           trap_valid_i, halt_i, resume_i,
`ifdef PC_COMPRESSED_EN
    input  is_compressed_i,
`endif
    output pc_o, pc_valid_o, misalign_o, misalign_addr_o, state_o
  );

endinterface

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: single-entry buffer for a redirect that arrived during a stall.
//   clk, rst    : clock, asynchronous active-low reset (buffer empties)
//   load        : capture load_target (overwrites any held entry)
//   clear       : drop the held entry
//   load_target : redirect target to capture
//   valid       : an entry is held
//   target      : held redirect target
module pc_redirect_hold #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_target,
  output logic            valid,
  output logic [XLEN-1:0] target
);

  // load takes precedence so a fresh redirect is never lost to a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      target <= load_target;
    end else if (clear) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with boot gating (LOAD/RUN/HALT), trap vectoring,
// branch/jump redirect buffered across stalls, halt/resume and misaligned-target rejection.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : pc_sequencer_if.slave (control inputs in, pc/valid/misalign/state out)
// Parameters: XLEN, RESET_VEC, TRAP_VEC, INSN_BYTES.
// Optional macro: PC_COMPRESSED_EN (2-byte step when is_compressed_i, halfword alignment).
// All outputs are registered; no combinational path from inputs to pc_o.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEFAULT_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEFAULT_TRAP_VEC),
  parameter int unsigned     INSN_BYTES = 4
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            hold_load, hold_clear, hold_valid;
  logic [XLEN-1:0] hold_target;
  logic [XLEN-1:0] step;
  logic [1:0]      align_mask;
  logic            redirect_bad, redirect_ok;

  pc_redirect_hold #(.XLEN(XLEN)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .load        (hold_load),
    .clear       (hold_clear),
    .load_target (bus.redirect_target_i),
    .valid       (hold_valid),
    .target      (hold_target)
  );

`ifdef PC_COMPRESSED_EN
  assign step       = bus.is_compressed_i ? XLEN'(2) : XLEN'(INSN_BYTES);
  assign align_mask = ALIGN_MASK_HALF;
`else
  assign step       = XLEN'(INSN_BYTES);
  assign align_mask = ALIGN_MASK_WORD;
`endif

  assign redirect_bad = bus.redirect_valid_i &&  is_misaligned(bus.redirect_target_i[1:0], align_mask);
  assign redirect_ok  = bus.redirect_valid_i && !is_misaligned(bus.redirect_target_i[1:0], align_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_LOAD;
      pc_q            <= RESET_VEC;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    hold_load       = 1'b0;
    hold_clear      = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (bus.trap_valid_i) begin
          pc_d       = TRAP_VEC;
          hold_clear = 1'b1;
          state_d    = ST_RUN;
        end else if (bus.loader_done_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.trap_valid_i) begin
          pc_d       = TRAP_VEC;
          hold_clear = 1'b1;
        end else begin
          // A rejected target only raises the flag; the cycle then behaves as if
          // no redirect had been requested (buffered target or sequential step).
          if (redirect_bad) begin
            misalign_d      = 1'b1;
            misalign_addr_d = bus.redirect_target_i;
          end
          if (redirect_ok && !bus.stall_i) begin
            pc_d = bus.redirect_target_i;
          end else if (redirect_ok && bus.stall_i) begin
            hold_load = 1'b1;
          end else if (hold_valid && !bus.stall_i) begin
            pc_d       = hold_target;
            hold_clear = 1'b1;
          end else if (!bus.stall_i) begin
            pc_d = pc_q + step;
          end
        end
        // The PC update above still lands on the edge that enters HALT.
        if (bus.halt_i) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (bus.trap_valid_i) begin
          pc_d       = TRAP_VEC;
          hold_clear = 1'b1;
          state_d    = ST_RUN;
        end else if (bus.resume_i) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_LOAD;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  assign bus.pc_o            = pc_q;
  assign bus.pc_valid_o      = (state_q == ST_RUN);
  assign bus.misalign_o      = misalign_q;
  assign bus.misalign_addr_o = misalign_addr_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(32)) bus ();

  pc_sequencer #(
    .XLEN       (32),
    .RESET_VEC  (32'h0000_0000),
    .TRAP_VEC   (32'h0000_0100),
    .INSN_BYTES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic        rv;
    logic [31:0] rt;
    logic        tr;
    logic        ha;
    logic        re;
    logic [31:0] pc;
    logic        v;
    logic        mis;
    logic [31:0] maddr;
    logic [1:0]  state;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic ld, logic st, logic rv, logic [31:0] rt, logic tr,
                              logic ha, logic re, logic [31:0] pc, logic v, logic mis,
                              logic [31:0] maddr, logic [1:0] state);
    vec_t r;
    r.ld = ld; r.st = st; r.rv = rv; r.rt = rt; r.tr = tr; r.ha = ha; r.re = re;
    r.pc = pc; r.v = v; r.mis = mis; r.maddr = maddr; r.state = state;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v, input logic mis,
                         input logic [31:0] maddr, input logic [1:0] state);
    chk({tag, " pc"},    bus.pc_o,                   pc);
    chk({tag, " valid"}, {31'd0, bus.pc_valid_o},    {31'd0, v});
    chk({tag, " mis"},   {31'd0, bus.misalign_o},    {31'd0, mis});
    chk({tag, " maddr"}, bus.misalign_addr_o,        maddr);
    chk({tag, " state"}, {30'd0, bus.state_o},       {30'd0, state});
  endtask

  task automatic drive(input logic ld, input logic st, input logic rv, input logic [31:0] rt,
                       input logic tr, input logic ha, input logic re);
    bus.loader_done_i     = ld;
    bus.stall_i           = st;
    bus.redirect_valid_i  = rv;
    bus.redirect_target_i = rt;
    bus.trap_valid_i      = tr;
    bus.halt_i            = ha;
    bus.resume_i          = re;
  endtask

  // Drive during the cycle, let one edge pass, sample 1 time unit later.
  task automatic step(input vec_t t);
    drive(t.ld, t.st, t.rv, t.rt, t.tr, t.ha, t.re);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          ld st rv rt            tr ha re | pc            v  mis maddr         state
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0000, 1, 0, 32'h0,   2'd1)); // leave LOAD, first fetch 0
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 1, 0, 32'h0,   2'd1)); // loader_done sticky
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0008, 1, 0, 32'h0,   2'd1));
    vecs.push_back(mk(0, 0, 1, 32'h20,       0, 0, 0, 32'h0000_0020, 1, 0, 32'h0,   2'd1)); // plain redirect
    vecs.push_back(mk(0, 1, 1, 32'h80,       0, 0, 0, 32'h0000_0020, 1, 0, 32'h0,   2'd1)); // buffered
    vecs.push_back(mk(0, 1, 1, 32'h90,       0, 0, 0, 32'h0000_0020, 1, 0, 32'h0,   2'd1)); // overwrite buffer
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0090, 1, 0, 32'h0,   2'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0094, 1, 0, 32'h0,   2'd1));
    vecs.push_back(mk(0, 0, 1, 32'h20,       0, 0, 0, 32'h0000_0020, 1, 0, 32'h0,   2'd1));
    vecs.push_back(mk(0, 0, 1, 32'h102,      0, 0, 0, 32'h0000_0024, 1, 1, 32'h102, 2'd1)); // misaligned
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0028, 1, 0, 32'h102, 2'd1)); // pulse ends
    vecs.push_back(mk(0, 1, 1, 32'h31,       0, 0, 0, 32'h0000_0028, 1, 1, 32'h31,  2'd1)); // misaligned while stalled
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_002C, 1, 0, 32'h31,  2'd1)); // not buffered
    vecs.push_back(mk(0, 1, 1, 32'h200,      0, 0, 0, 32'h0000_002C, 1, 0, 32'h31,  2'd1)); // pending 0x200
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 32'h0000_0100, 1, 0, 32'h31,  2'd1)); // trap under stall
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0000_0100, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0104, 1, 0, 32'h31,  2'd1)); // pending gone
    vecs.push_back(mk(0, 0, 1, 32'h300,      1, 0, 0, 32'h0000_0100, 1, 0, 32'h31,  2'd1)); // trap beats redirect
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0104, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 0, 1, 32'h40,       0, 0, 0, 32'h0000_0040, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h0000_0044, 0, 0, 32'h31,  2'd2)); // halt after update
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0044, 0, 0, 32'h31,  2'd2));
    vecs.push_back(mk(0, 0, 1, 32'h500,      0, 0, 0, 32'h0000_0044, 0, 0, 32'h31,  2'd2)); // redirect ignored
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h0000_0044, 1, 0, 32'h31,  2'd1)); // resume wins in HALT
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0048, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h0000_0048, 0, 0, 32'h31,  2'd2)); // halt wins in RUN
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h0000_0100, 1, 0, 32'h31,  2'd1)); // trap leaves HALT
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0104, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 1, 1, 32'h600,      0, 0, 0, 32'h0000_0104, 1, 0, 32'h31,  2'd1)); // pending 0x600
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0000_0104, 0, 0, 32'h31,  2'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0000_0104, 1, 0, 32'h31,  2'd1)); // pending survives HALT
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0600, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0604, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 32'hFFFF_FFF8, 1, 0, 32'h31, 2'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0000, 1, 0, 32'h31,  2'd1)); // wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 1, 0, 32'h31,  2'd1));
    vecs.push_back(mk(0, 1, 1, 32'h700,      0, 0, 0, 32'h0000_0004, 1, 0, 32'h31,  2'd1)); // pending before reset

    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0, 0);
`ifdef PC_COMPRESSED_EN
    bus.is_compressed_i = 1'b0;
`endif
    #3;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 32'h0, 2'd0);
    #4 rst = 1'b1;

    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("load%0d", i), 32'h0, 1'b0, 1'b0, 32'h0, 2'd0);
    end

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      chk_all($sformatf("row%0d", i), vecs[i].pc, vecs[i].v, vecs[i].mis, vecs[i].maddr, vecs[i].state);
    end

    // Asynchronous reset in the middle of a stalled cycle, with an entry pending.
    drive(0, 1, 0, 32'h0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 2'd0);
    #1 rst = 1'b1;
    drive(1, 0, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("reboot0", 32'h0, 1'b1, 1'b0, 32'h0, 2'd1);
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("reboot1", 32'h4, 1'b1, 1'b0, 32'h0, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
